// File: rtl/maze_pkg.sv
// Shared types and constants for the maze memory block.
package maze_pkg;

    localparam int unsigned MAZE_WIDTH = 6;
    localparam int unsigned MAZE_DIM   = 2 ** MAZE_WIDTH;

    typedef enum logic [1:0] {
        StEmpty,
        StLoad,
        StServe,
        StFrozen
    } maze_state_e;

endpackage

// File: rtl/maze_cell_ram.sv
// Wall and path-mark storage: one row-write, one bit-read, one bit-set, one row-readback port.
// Contents are deliberately not reset; a row write clears that row's marks instead.
module maze_cell_ram #(
    parameter int unsigned maze_width = 6
) (
    input  logic                       clk,
    input  logic                       row_we,
    input  logic [maze_width-1:0]      row_addr,
    input  logic [2**maze_width-1:0]   row_data,
    input  logic [maze_width-1:0]      bit_row,
    input  logic [maze_width-1:0]      bit_col,
    output logic                       bit_wall,
    output logic                       bit_path,
    input  logic                       set_en,
    input  logic [maze_width-1:0]      set_row,
    input  logic [maze_width-1:0]      set_col,
    input  logic [maze_width-1:0]      rb_row,
    output logic [2**maze_width-1:0]   rb_path
);

    localparam int unsigned Dim = 2 ** maze_width;

    logic [Dim-1:0] wall_q [Dim];
    logic [Dim-1:0] path_q [Dim];

    always_ff @(posedge clk) begin
        if (row_we) begin
            wall_q[row_addr] <= row_data;
            path_q[row_addr] <= '0;
        end
        if (set_en) begin
            path_q[set_row][set_col] <= 1'b1;
        end
    end

    assign bit_wall = wall_q[bit_row][bit_col];
    assign bit_path = path_q[bit_row][bit_col];
    assign rb_path  = path_q[rb_row];

endmodule

// File: rtl/maze_memory.sv
// Maze store for a solver: row-by-row load, then per-cell wall reads and path marking.
// Optional path statistics outputs under MAZE_MEMORY_STATS_EN.
module maze_memory
    import maze_pkg::*;
#(
    parameter int unsigned maze_width = MAZE_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [2**maze_width-1:0]   load_data,
    input  logic [maze_width-1:0]      row,
    input  logic [maze_width-1:0]      col,
    input  logic                       maze_oe,
    input  logic                       maze_we,
    output logic                       maze_in,
    input  logic                       done,
    input  logic [maze_width-1:0]      rd_row,
    output logic [2**maze_width-1:0]   rd_path,
`ifdef MAZE_MEMORY_STATS_EN
    output logic [2*maze_width:0]      path_len,
    output logic                       revisit,
`endif
    output logic                       busy
);

    maze_state_e           state_q, state_d;
    logic [maze_width-1:0] load_cnt_q, load_cnt_d;
    logic                  maze_in_q, maze_in_d;
    logic                  row_we, set_en;
    logic                  bit_wall, bit_path;

    maze_cell_ram #(
        .maze_width (maze_width)
    ) u_cells (
        .clk      (clk),
        .row_we   (row_we),
        .row_addr (load_cnt_q),
        .row_data (load_data),
        .bit_row  (row),
        .bit_col  (col),
        .bit_wall (bit_wall),
        .bit_path (bit_path),
        .set_en   (set_en),
        .set_row  (row),
        .set_col  (col),
        .rb_row   (rd_row),
        .rb_path  (rd_path)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StEmpty;
            load_cnt_q <= '0;
            maze_in_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            maze_in_q  <= maze_in_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        maze_in_d  = maze_in_q;
        load_ready = 1'b0;
        busy       = 1'b0;
        row_we     = 1'b0;
        set_en     = 1'b0;
        unique case (state_q)
            StEmpty: state_d = StLoad;
            StLoad: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    row_we     = 1'b1;
                    load_cnt_d = load_cnt_q + 1'b1;
                    if (load_cnt_q == '1) begin
                        state_d = StServe;
                    end
                end
            end
            StServe: begin
                busy   = 1'b1;
                set_en = maze_we;
                if (maze_oe) begin
                    maze_in_d = bit_wall;
                end
                if (done) begin
                    state_d = StFrozen;
                end
            end
            StFrozen: state_d = StFrozen;
            default:  state_d = StEmpty;
        endcase
    end

    assign maze_in = maze_in_q;

`ifdef MAZE_MEMORY_STATS_EN
    logic [2*maze_width:0] path_len_q;
    logic                  revisit_q;

    // Statistics restart when a new load begins, i.e. on the EMPTY -> LOAD step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            path_len_q <= '0;
            revisit_q  <= 1'b0;
        end else if (state_q == StEmpty) begin
            path_len_q <= '0;
            revisit_q  <= 1'b0;
        end else if (set_en) begin
            if (bit_path) begin
                revisit_q <= 1'b1;
            end else begin
                path_len_q <= path_len_q + 1'b1;
            end
        end
    end

    assign path_len = path_len_q;
    assign revisit  = revisit_q;
`endif

endmodule

// File: tb/tb_maze_memory.sv
// Directed bench for maze_memory: load, serve table, freeze, and reset-abort sequences.
// Build with MAZE_MEMORY_STATS_EN to also check path_len/revisit.
module tb_maze_memory;

    localparam int W = 6;
    localparam logic [63:0] B10 = 64'd1 << 10;
    localparam logic [63:0] B11 = 64'd1 << 11;
    localparam logic [63:0] B12 = 64'd1 << 12;
    localparam logic [63:0] B20 = 64'd1 << 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [63:0]   load_data = '0;
    logic [W-1:0]  row = '0;
    logic [W-1:0]  col = '0;
    logic          maze_oe = 1'b0;
    logic          maze_we = 1'b0;
    logic          maze_in;
    logic          done = 1'b0;
    logic [W-1:0]  rd_row = 6'd5;
    logic [63:0]   rd_path;
    logic          busy;
`ifdef MAZE_MEMORY_STATS_EN
    logic [2*W:0]  path_len;
    logic          revisit;
`endif

    int checks = 0;
    int failures = 0;

    maze_memory #(
        .maze_width (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .row        (row),
        .col        (col),
        .maze_oe    (maze_oe),
        .maze_we    (maze_we),
        .maze_in    (maze_in),
        .done       (done),
        .rd_row     (rd_row),
        .rd_path    (rd_path),
`ifdef MAZE_MEMORY_STATS_EN
        .path_len   (path_len),
        .revisit    (revisit),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // pat 0: all walls except an open row 5; pat 1: only the diagonal cell of each row is open.
    function automatic logic [63:0] row_val(input int pat, input int r);
        logic [63:0] one;
        one = 64'd1;
        if (pat == 0) return (r == 5) ? 64'd0 : ~64'd0;
        return ~(one << r);
    endfunction

    task automatic load_rows(input int n, input int pat);
        int budget;
        for (int r = 0; r < n; r++) begin
            load_data  = row_val(pat, r);
            load_valid = 1'b1;
            budget = 0;
            while (load_ready !== 1'b1 && budget < 8) begin
                tick();
                budget++;
            end
            if (load_ready !== 1'b1) begin
                check("load_ready_timeout", {63'd0, load_ready}, 64'd1);
                load_valid = 1'b0;
                return;
            end
            tick();
        end
        load_valid = 1'b0;
    endtask

    typedef struct {
        logic        oe;
        logic        we;
        logic        dn;
        logic [5:0]  r;
        logic [5:0]  c;
        logic        exp_in;
        logic        exp_busy;
        logic [63:0] exp_path;
        int          exp_len;
        logic        exp_rev;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 6'd5, 6'd10, 1'b0, 1'b1, 64'd0, 0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 6'd4, 6'd10, 1'b0, 1'b1, 64'd0, 0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 6'd4, 6'd10, 1'b1, 1'b1, 64'd0, 0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 6'd5, 6'd10, 1'b1, 1'b1, B10, 1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 6'd5, 6'd11, 1'b1, 1'b1, B10 | B11, 2, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 6'd5, 6'd11, 1'b1, 1'b1, B10 | B11, 2, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 6'd5, 6'd20, 1'b0, 1'b1, B10 | B11 | B20, 3, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 6'd0, 6'd0 - 6'd1, 1'b1, 1'b1, B10 | B11 | B20, 3, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 6'd5, 6'd0, 1'b0, 1'b1, B10 | B11 | B20, 3, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 6'd5, 6'd12, 1'b0, 1'b0, B10 | B11 | B12 | B20, 4, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 6'd4, 6'd0, 1'b0, 1'b0, B10 | B11 | B12 | B20, 4, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 6'd5, 6'd13, 1'b0, 1'b0, B10 | B11 | B12 | B20, 4, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 6'd4, 6'd1, 1'b0, 1'b0, B10 | B11 | B12 | B20, 4, 1'b1};

        // Reset state
        tick();
        tick();
        check("rst_maze_in", {63'd0, maze_in}, 64'd1);
        check("rst_load_ready", {63'd0, load_ready}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        rst = 1'b0;
        check("empty_load_ready", {63'd0, load_ready}, 64'd0);
        tick();
        check("load_state_ready", {63'd0, load_ready}, 64'd1);

        // Full load of pattern 0
        load_rows(64, 0);
        check("after_load_ready", {63'd0, load_ready}, 64'd0);
        check("after_load_busy", {63'd0, busy}, 64'd1);
        check("after_load_path5", rd_path, 64'd0);

        // SERVE table
        for (int i = 0; i < 13; i++) begin
            maze_oe = vecs[i].oe;
            maze_we = vecs[i].we;
            done    = vecs[i].dn;
            row     = vecs[i].r;
            col     = vecs[i].c;
            tick();
            check($sformatf("vec%0d_maze_in", i), {63'd0, maze_in}, {63'd0, vecs[i].exp_in});
            check($sformatf("vec%0d_busy", i), {63'd0, busy}, {63'd0, vecs[i].exp_busy});
            check($sformatf("vec%0d_rd_path", i), rd_path, vecs[i].exp_path);
            check($sformatf("vec%0d_load_ready", i), {63'd0, load_ready}, 64'd0);
`ifdef MAZE_MEMORY_STATS_EN
            check($sformatf("vec%0d_path_len", i), 64'(path_len), 64'(vecs[i].exp_len));
            check($sformatf("vec%0d_revisit", i), {63'd0, revisit}, {63'd0, vecs[i].exp_rev});
`endif
        end
        maze_oe = 1'b0;
        maze_we = 1'b0;
        done    = 1'b0;

        // Reset from FROZEN: marks survive, outputs return to reset values
        #2 rst = 1'b1;
        #1;
        check("frz_rst_maze_in", {63'd0, maze_in}, 64'd1);
        check("frz_rst_busy", {63'd0, busy}, 64'd0);
        check("frz_rst_path_kept", rd_path, B10 | B11 | B12 | B20);
`ifdef MAZE_MEMORY_STATS_EN
        check("frz_rst_path_len", 64'(path_len), 64'd0);
`endif
        tick();
        rst = 1'b0;
        check("rel_empty_ready", {63'd0, load_ready}, 64'd0);

        // Partial load with stray strobes held high; they must not act in LOAD
        maze_oe = 1'b1;
        maze_we = 1'b1;
        done    = 1'b1;
        row     = 6'd5;
        col     = 6'd0;
        load_rows(30, 1);
        check("load_oe_ignored", {63'd0, maze_in}, 64'd1);
        check("load_busy", {63'd0, busy}, 64'd0);
        check("load_still_ready", {63'd0, load_ready}, 64'd1);
        maze_oe = 1'b0;
        maze_we = 1'b0;
        done    = 1'b0;

        // Abort mid-load; reload must restart at row 0
        #2 rst = 1'b1;
        #1;
        check("abort_maze_in", {63'd0, maze_in}, 64'd1);
        check("abort_load_ready", {63'd0, load_ready}, 64'd0);
        tick();
        rst = 1'b0;
        load_rows(64, 1);
        check("reload_busy", {63'd0, busy}, 64'd1);
        check("reload_path5_clear", rd_path, 64'd0);
`ifdef MAZE_MEMORY_STATS_EN
        check("reload_path_len", 64'(path_len), 64'd0);
        check("reload_revisit", {63'd0, revisit}, 64'd0);
`endif
        maze_oe = 1'b1;
        row = 6'd0; col = 6'd0;
        tick();
        check("reload_r0c0", {63'd0, maze_in}, 64'd0);
        row = 6'd0; col = 6'd1;
        tick();
        check("reload_r0c1", {63'd0, maze_in}, 64'd1);
        row = 6'd7; col = 6'd7;
        tick();
        check("reload_r7c7", {63'd0, maze_in}, 64'd0);
        row = 6'd63; col = 6'd63;
        tick();
        check("reload_r63c63", {63'd0, maze_in}, 64'd0);
        maze_oe = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
